// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the elastic pipeline-stage register: state
// encodings, the default 160-bit payload packing and the pc keep mask.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } st_e;

  localparam int WORD_W     = 32;
  localparam int PAYLOAD_W  = 5 * WORD_W;

  // Word offsets inside the default packed payload.
  localparam int INSTR_LSB  = 0;
  localparam int PC_LSB     = 32;
  localparam int EXT_LSB    = 64;
  localparam int ALU_LSB    = 96;
  localparam int DM_LSB     = 128;

  // Keeps only the pc word when a stage is flushed, so exception
  // reporting still sees the faulting pc.
  localparam logic [PAYLOAD_W-1:0] PC_KEEP_MASK =
    {{(PAYLOAD_W - PC_LSB - WORD_W){1'b0}}, {WORD_W{1'b1}}, {PC_LSB{1'b0}}};

  // Occupancy count of a state.
  function automatic logic [1:0] st_level(input st_e s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/pipe_stage_entry.sv
// One payload register with load enable and a masked clear used on flush.
module pipe_stage_entry #(
  parameter int                DATA_W    = 160,
  parameter logic [DATA_W-1:0] KEEP_MASK = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] q_reg;
  logic [DATA_W-1:0] q_next;

  // Per-bit next value: clear keeps only the masked bits, load takes d.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
    assign q_next[gi] = clear ? (q_reg[gi] & KEEP_MASK[gi]) :
                        load  ? d[gi] : q_reg[gi];
  end

  // Payload register; reset clears everything including kept bits.
  always_ff @(posedge clk) begin
    if (rst) q_reg <= '0;
    else     q_reg <= q_next;
  end

  assign q = q_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: valid/ready handshake, optional
// two-entry skid buffer with registered in_ready, flush with kept bits.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = 160,
  parameter bit                SKID      = 1'b1,
  parameter logic [DATA_W-1:0] KEEP_MASK = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        level
);

  st_e st_reg;
  st_e st_next;

  logic              in_fire;
  logic              out_fire;
  logic              main_load;
  logic              main_from_skid;
  logic              skid_load;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;

  assign out_valid = (st_reg != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign level     = st_level(st_reg);
  assign out_data  = main_q;
  assign main_d    = main_from_skid ? skid_q : in_data;

  if (SKID) begin : g_skid
    // Ready comes from the state register only, so a downstream stall
    // never ripples combinationally into the upstream stage.
    assign in_ready = (st_reg != ST_FULL);

    pipe_stage_entry #(
      .DATA_W   (DATA_W),
      .KEEP_MASK(KEEP_MASK)
    ) u_skid (
      .clk  (clk),
      .rst  (rst),
      .load (skid_load),
      .clear(flush),
      .d    (in_data),
      .q    (skid_q)
    );
  end else begin : g_noskid
    // Single entry: accept whenever the head leaves or is absent.
    assign in_ready = out_ready | ~out_valid;
    assign skid_q   = '0;
  end

  pipe_stage_entry #(
    .DATA_W   (DATA_W),
    .KEEP_MASK(KEEP_MASK)
  ) u_main (
    .clk  (clk),
    .rst  (rst),
    .load (main_load),
    .clear(flush),
    .d    (main_d),
    .q    (main_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) st_reg <= ST_EMPTY;
    else     st_reg <= st_next;
  end

  // Next state and payload load controls; flush overrides the handshake.
  always_comb begin
    st_next        = st_reg;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    case (st_reg)
      ST_EMPTY: begin
        if (in_fire) begin
          st_next   = ST_ONE;
          main_load = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_load = 1'b1;
        end else if (in_fire) begin
          st_next   = ST_FULL;
          skid_load = 1'b1;
        end else if (out_fire) begin
          st_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          st_next        = ST_ONE;
          main_load      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: st_next = ST_EMPTY;
    endcase
    if (flush) begin
      st_next        = ST_EMPTY;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
    end
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline-stage register for the five-stage MIPS core. It replaces the fixed per-stage latches between F/D/E/M/W with one generic block. The payload is a flat bus into which the stage packs instr, pc and data words. The block adds a valid/ready handshake, an optional two-entry skid buffer for a registered in_ready, and a synchronous flush that keeps selected payload bits, such as the pc for exception reporting.

## Interface
- DATA_W, 160: payload width in bits (5 × 32-bit words by default).
- SKID, 1: 1 selects a two-entry skid buffer with registered in_ready; 0 selects a single entry with combinational in_ready.
- KEEP_MASK, {DATA_W{1'b0}}: payload bits kept on flush; all other bits are cleared to 0.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- flush  input  1  synchronous flush: discards all held entries and the current input beat.
- in_valid  input  1  upstream stage presents a beat.
- in_ready  output  1  this stage accepts the beat this cycle.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  `main` holds a valid beat.
- out_ready  input  1  downstream stage accepts this cycle; this is the stall input, deasserted to stall.
- out_data  output  DATA_W  payload of `main`.
- level  output  2  occupancy: 0, 1 or 2.

## Operation
- Storage:
  - `main` register holds the head beat and drives out_data.
  - `skid` register holds the second beat; it exists only when SKID=1.
  - State register `st` takes the values EMPTY, ONE or FULL.
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - out_valid = (st != EMPTY).
  - level = 0 / 1 / 2 for EMPTY / ONE / FULL.
- SKID=1 behaviour:
  - in_ready = (st != FULL), decoded from registers only.
  - EMPTY: on in_fire → ONE, and main ← in_data.
  - ONE with in_fire & out_fire → stay ONE, and main ← in_data.
  - ONE with in_fire only → FULL, and skid ← in_data.
  - ONE with out_fire only → EMPTY.
  - FULL: in_ready=0. On out_fire → ONE, and main ← skid.
- SKID=0 behaviour:
  - FULL never occurs.
  - in_ready = out_ready | ~out_valid.
  - EMPTY/ONE transitions are the same as for SKID=1.
- Flush:
  - st ← EMPTY.
  - main ← main & KEEP_MASK and skid ← skid & KEEP_MASK.
  - The in_fire beat of the same cycle is dropped, not stored.
  - out_fire in the flush cycle still counts as completed downstream.
- Priority: rst > flush > handshake.
- Data in `main` and `skid` changes only on the transitions listed above. Data is held during stall, so out_data is stable while out_valid & ~out_ready.

## Timing
- Reset values:
  - st=EMPTY, main=0, skid=0.
  - out_valid=0, level=0, out_data=0.
  - in_ready=1 in the first cycle after reset release (SKID=1); for SKID=0 in_ready is 1 because out_valid=0.
- Latency: a beat accepted at edge n appears on out_data/out_valid after edge n, i.e. 1 cycle.
- Throughput: 1 beat/cycle while out_ready=1 (both SKID settings).
- Stall behaviour, SKID=1: the stage absorbs one extra beat after out_ready drops. in_ready falls the cycle after FULL is entered, never combinationally from out_ready.
- Order: strict FIFO. The skid beat always follows the main beat.
- Simultaneous flush and rst: rst wins; all payload is cleared, including KEEP_MASK bits.
- Reset mid-stall: any beat in FULL/ONE is lost; no output glitch beyond the reset values.

## Structure
- A shared package `pipe_pkg` holds:
  - the state encodings ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2;
  - field offsets INSTR_LSB, PC_LSB, EXT_LSB, ALU_LSB, DM_LSB for the default 160-bit packing;
  - a helper mask constant PC_KEEP_MASK.
- Sub-module `pipe_stage_entry` is natural: one DATA_W register with load enable and masked clear, instantiated as `main` and `skid`.
- Top level contains only the state machine and the muxes.

## Test plan
- Reset then stream: rst high 2 cycles; then send in_valid with data 1, 2, 3, 4 on consecutive cycles, out_ready=1. Required: out_data 1..4 one cycle later each, level never exceeds 1, in_ready=1 throughout.
- Stall absorb (SKID=1): send 0xA at edge 0 and 0xB at edge 1, with out_ready=0 from edge 1. Required: level=2 and in_ready=0 after edge 1; 0xA held on out_data; after out_ready=1, 0xA then 0xB, no loss or duplication.
- Combinational ready (SKID=0): hold out_valid=1 with out_ready=0. Required: in_ready=0 in the same cycle; raising out_ready gives in_ready=1 in the same cycle.
- Flush with keep: KEEP_MASK=PC_KEEP_MASK, FULL state with pc fields 0x3004/0x3008, flush=1 while in_valid=1. Required: next cycle out_valid=0, level=0, pc field of main=0x3004, other fields 0, and the input beat is not delivered.
- Flush vs reset: assert rst and flush together in FULL state. Required: all payload 0 (pc included), level=0, in_ready=1 after release.
- Random stall soak: random in_valid/out_ready for 10k cycles against a scoreboard. Required: in-order delivery, out_data stable while stalled, in_ready never depends combinationally on out_ready when SKID=1.
